// File: rtl/segment_transition_ctl_if.sv
// segment_transition_ctl_if: request, timing, trigger and status bundle for segment_transition_ctl
interface segment_transition_ctl_if #(parameter int SysTimeWidth = 64);
  logic update;
  logic req_segment;
  logic [7:0] transition_mode;
  logic [SysTimeWidth-1:0] transition_value;
  logic [15:0] rep;
  logic [SysTimeWidth-1:0] sys_time;
  logic [3:0] gpio_in;
  logic loop_end;
  logic segment;
  logic switch;
  logic stop;
  logic pending;
  modport master (
    output update, req_segment, transition_mode, transition_value, rep, sys_time, gpio_in, loop_end,
    input segment, switch, stop, pending
  );
  modport slave (
    input update, req_segment, transition_mode, transition_value, rep, sys_time, gpio_in, loop_end,
    output segment, switch, stop, pending
  );
endinterface

// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl: read-segment switch controller; GPIO trigger mode enabled by AUTD3_TRANSITION_GPIO_EN
module segment_transition_ctl #(parameter int SysTimeWidth = 64) (
  input logic clk,
  input logic rst_n,
  segment_transition_ctl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_IDX, WAIT_TIME, WAIT_GPIO, EXT_RUN} state_t;
  localparam logic [7:0] MODE_IDX  = 8'h00;
  localparam logic [7:0] MODE_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO = 8'h02;
  localparam logic [7:0] MODE_EXT  = 8'hF0;
  state_t state, state_n, wait_state;
  logic segment, segment_n, switch_q, switch_n, stop, stop_n, pending, pending_n;
  logic [15:0] cnt, cnt_n, l_rep, l_rep_n;
  logic inf, inf_n, l_seg, l_seg_n, time_ge, time_ge_n;
  logic [SysTimeWidth-1:0] l_val, l_val_n;
  logic gpio_rise, mode_ok, met, accept;
`ifdef AUTD3_TRANSITION_GPIO_EN
  logic [3:0] s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.gpio_in;
      s2 <= s1;
      s3 <= s2;
    end
  assign gpio_rise = s2[l_val[1:0]] & ~s3[l_val[1:0]];
  assign mode_ok = bus.transition_mode inside {MODE_IDX, MODE_TIME, MODE_GPIO, MODE_EXT};
`else
  assign gpio_rise = 1'b0;
  assign mode_ok = bus.transition_mode inside {MODE_IDX, MODE_TIME, MODE_EXT};
`endif
  assign accept = bus.update & mode_ok;
  // EXT_RUN with pending set means the initial switch fires on this edge
  assign met = pending & ((state == WAIT_IDX & bus.loop_end) | (state == WAIT_TIME & time_ge) |
                          (state == WAIT_GPIO & gpio_rise) | state == EXT_RUN) |
               (state == EXT_RUN & ~pending & bus.loop_end);
  assign wait_state = bus.transition_mode == MODE_IDX  ? WAIT_IDX  :
                      bus.transition_mode == MODE_TIME ? WAIT_TIME :
                      bus.transition_mode == MODE_GPIO ? WAIT_GPIO : EXT_RUN;
  always_comb begin
    state_n = state;
    segment_n = segment;
    switch_n = 1'b0;
    stop_n = stop;
    pending_n = pending;
    cnt_n = cnt;
    inf_n = inf;
    l_seg_n = l_seg;
    l_val_n = l_val;
    l_rep_n = l_rep;
    time_ge_n = bus.sys_time >= l_val;
    if (met) begin
      segment_n = ~segment;
      switch_n = 1'b1;
      pending_n = 1'b0;
      cnt_n = l_rep;
      inf_n = &l_rep;
      stop_n = 1'b0;
      state_n = state == EXT_RUN ? EXT_RUN : IDLE;
    end else if (state == IDLE & bus.loop_end & ~stop & ~inf) begin
      stop_n = cnt == 16'd0;
      cnt_n = cnt == 16'd0 ? cnt : cnt - 16'd1;
    end
    // a new request is judged against the segment as it will be after this edge
    if (accept) begin
      l_seg_n = bus.req_segment;
      l_val_n = bus.transition_value;
      l_rep_n = bus.rep;
      time_ge_n = bus.sys_time >= bus.transition_value;
      if (bus.transition_mode != MODE_EXT && bus.req_segment == segment_n) begin
        state_n = IDLE;
        pending_n = 1'b0;
        cnt_n = bus.rep;
        inf_n = &bus.rep;
        stop_n = 1'b0;
      end else begin
        state_n = wait_state;
        pending_n = 1'b1;
        stop_n = bus.transition_mode == MODE_EXT ? 1'b0 : stop_n;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      segment <= 1'b0;
      switch_q <= 1'b0;
      stop <= 1'b0;
      pending <= 1'b0;
      cnt <= 16'hFFFF;
      inf <= 1'b1;
      l_seg <= 1'b0;
      l_val <= '0;
      l_rep <= 16'hFFFF;
      time_ge <= 1'b0;
    end else begin
      state <= state_n;
      segment <= segment_n;
      switch_q <= switch_n;
      stop <= stop_n;
      pending <= pending_n;
      cnt <= cnt_n;
      inf <= inf_n;
      l_seg <= l_seg_n;
      l_val <= l_val_n;
      l_rep <= l_rep_n;
      time_ge <= time_ge_n;
    end
  assign bus.segment = segment;
  assign bus.switch = switch_q;
  assign bus.stop = stop;
  assign bus.pending = pending;
endmodule

// File: tb/tb_segment_transition_ctl.sv
// tb_segment_transition_ctl: table-driven scoreboard bench for segment_transition_ctl
module tb_segment_transition_ctl;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  segment_transition_ctl_if #(.SysTimeWidth(W)) bus ();
  segment_transition_ctl #(.SysTimeWidth(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic upd;
    logic seg;
    logic [7:0] mode;
    logic [W-1:0] val;
    logic [15:0] rep;
    logic [W-1:0] t;
    logic le;
    logic [3:0] gpio;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [3:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int row_no = 0;
  function automatic vec_t mk(input logic u, input logic s, input logic [7:0] m, input logic [W-1:0] v,
                              input logic [15:0] r, input logic [W-1:0] t, input logic l,
                              input logic [3:0] g, input logic [3:0] e);
    vec_t x;
    x = '{u, s, m, v, r, t, l, g, e};
    return x;
  endfunction
  function automatic void add(input vec_t x);
    tbl.push_back(x);
  endfunction
  function automatic vec_t idle(input logic [W-1:0] t, input logic l, input logic [3:0] e);
    return mk(1'b0, 1'b0, 8'h00, '0, 16'h0, t, l, 4'h0, e);
  endfunction
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {seg,sw,stop,pend} got %b expected %b", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t x);
    logic [3:0] e;
    @(negedge clk);
    bus.update = x.upd;
    bus.req_segment = x.seg;
    bus.transition_mode = x.mode;
    bus.transition_value = x.val;
    bus.rep = x.rep;
    bus.sys_time = x.t;
    bus.loop_end = x.le;
    bus.gpio_in = x.gpio;
    sb.push_back(x.exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    row_no++;
    check($sformatf("row%0d", row_no), {bus.segment, bus.switch, bus.stop, bus.pending}, e);
  endtask
  initial begin
    bus.update = 1'b0;
    bus.req_segment = 1'b0;
    bus.transition_mode = 8'h00;
    bus.transition_value = '0;
    bus.rep = 16'h0;
    bus.sys_time = 64'd1000;
    bus.loop_end = 1'b0;
    bus.gpio_in = 4'h0;
    // sync-index switch after ten idle cycles, infinite repetitions
    add(mk(1, 1, 8'h00, '0, 16'hFFFF, 1000, 0, 0, 4'b0001));
    for (int i = 0; i < 9; i++) add(idle(1000, 0, 4'b0001));
    add(idle(1000, 1, 4'b1100));
    add(idle(1000, 0, 4'b1000));
    add(idle(1000, 1, 4'b1000));
    // sys-time deadline 1005, then REP=2 -> three loops then stop
    add(mk(1, 0, 8'h01, 1005, 16'd2, 1000, 0, 0, 4'b1001));
    for (int i = 1001; i <= 1005; i++) add(idle(i, 0, 4'b1001));
    add(idle(1006, 0, 4'b0100));
    add(idle(1006, 1, 4'b0000));
    add(idle(1006, 1, 4'b0000));
    add(idle(1006, 1, 4'b0010));
    add(idle(1006, 1, 4'b0010));
    add(idle(1006, 0, 4'b0010));
    add(mk(1, 0, 8'h00, '0, 16'd1, 1000, 0, 0, 4'b0000));
    add(idle(1000, 1, 4'b0000));
    add(idle(1000, 1, 4'b0010));
    // deadline already past, REP=0
    add(mk(1, 1, 8'h01, 900, 16'd0, 1000, 0, 0, 4'b0011));
    add(idle(1000, 0, 4'b1100));
    add(idle(1000, 1, 4'b1010));
    // EXT mode then an unknown mode
    add(mk(1, 0, 8'hF0, '0, 16'd5, 1000, 0, 0, 4'b1001));
    add(idle(1000, 0, 4'b0100));
    add(idle(1000, 1, 4'b1100));
    add(idle(1000, 0, 4'b1000));
    add(idle(1000, 1, 4'b0100));
    add(idle(1000, 1, 4'b1100));
    add(idle(1000, 1, 4'b0100));
    add(mk(1, 1, 8'h7F, 7, 16'd9, 1000, 0, 0, 4'b0000));
    add(idle(1000, 0, 4'b0000));
    // latest request wins over a pending one
    add(mk(1, 1, 8'h00, '0, 16'd0, 1000, 0, 0, 4'b0001));
    add(mk(1, 1, 8'h01, 5000, 16'd0, 1000, 0, 0, 4'b0001));
    add(idle(1000, 1, 4'b0001));
    add(idle(5000, 0, 4'b0001));
    add(idle(5000, 0, 4'b1100));
    // update coincident with met condition; coincident LOOP_END not counted
    add(mk(1, 0, 8'h00, '0, 16'd7, 1000, 0, 0, 4'b1001));
    add(mk(1, 1, 8'h00, '0, 16'd3, 1000, 1, 0, 4'b0101));
    add(idle(1000, 1, 4'b1100));
    for (int i = 0; i < 3; i++) add(idle(1000, 1, 4'b1000));
    add(idle(1000, 1, 4'b1010));
    repeat (2) @(negedge clk);
    check("reset_state", {bus.segment, bus.switch, bus.stop, bus.pending}, 4'b0000);
    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i]);
    // pending request discarded by reset
    apply(mk(1, 0, 8'h00, '0, 16'hFFFF, 1000, 0, 0, 4'b1011));
    #2 rst_n = 1'b0;
    #1 check("async_reset", {bus.segment, bus.switch, bus.stop, bus.pending}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle(1000, 1, 4'b0000));
    apply(idle(1000, 0, 4'b0000));
    tbl.delete();
`ifdef AUTD3_TRANSITION_GPIO_EN
    add(mk(1, 1, 8'h02, 2, 16'hFFFF, 1000, 0, 4'h0, 4'b0001));
    for (int i = 0; i < 3; i++) add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h2, 4'b0001));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h0, 4'b0001));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h4, 4'b0001));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h4, 4'b0001));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h4, 4'b1100));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 0, 4'h4, 4'b1000));
`else
    add(mk(1, 1, 8'h02, 2, 16'hFFFF, 1000, 0, 4'h4, 4'b0000));
    add(mk(0, 0, 8'h00, '0, 16'h0, 1000, 1, 4'h0, 4'b0000));
`endif
    foreach (tbl[i]) apply(tbl[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
